// File: rtl/sqrt_pkg.sv
// Shared state encoding and defaults for the square-root iteration sequencer.
package sqrt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_INIT = 3'd1;
  localparam state_t ST_ITER = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam int unsigned MAX_ITER_DEF = 256;

  // States in which the root register and select flag advance.
  function automatic logic is_pipe_state(input state_t s);
    return (s == ST_INIT) || (s == ST_ITER);
  endfunction

endpackage

// File: rtl/sqrt_pipe_ctrl_if.sv
// Operand handshake, datapath strobes and result handshake of the sqrt sequencer.
interface sqrt_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 9
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic             cmp_gt_i;
  logic             wr_input_o;
  logic             wr_square_s_o;
  logic             wr_square_o;
  logic             en_pipe_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             busy_o;
  logic             err_o;
  logic [CNT_W-1:0] iter_cnt_o;

  // master: the controller; slave: operand source, datapath and result consumer.
  modport master (
    input  in_valid_i, cmp_gt_i, out_ready_i,
    output in_ready_o, wr_input_o, wr_square_s_o, wr_square_o, en_pipe_o,
           out_valid_o, busy_o, err_o, iter_cnt_o
  );

  modport slave (
    output in_valid_i, cmp_gt_i, out_ready_i,
    input  in_ready_o, wr_input_o, wr_square_s_o, wr_square_o, en_pipe_o,
           out_valid_o, busy_o, err_o, iter_cnt_o
  );

endinterface

// File: rtl/sqrt_lat_shift.sv
// Delays the en_pipe issue bit by the comparator latency so cmp_gt_i is only
// trusted in cycles that answer a real datapath step.
module sqrt_lat_shift #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic qual
);

  generate
    if (LAT == 0) begin : g_comb
      assign qual = issue;
    end else begin : g_sr
      logic [LAT-1:0] sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          sr <= '0;
        end else begin
          sr[0] <= issue;
          for (int unsigned i = 1; i < LAT; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end

      assign qual = sr[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/sqrt_pipe_ctrl.sv
// Sequencer for the square-root iteration datapath: accepts an operand, drives
// the square/root strobes until the comparator fires or MAX_ITER is hit.
module sqrt_pipe_ctrl
  import sqrt_pkg::*;
#(
  parameter int unsigned CMP_LAT  = 1,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF,
  parameter int unsigned CNT_W    = 9
) (
  input logic              clk,
  input logic              rst,
  sqrt_pipe_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] ITER_LIM  = CNT_W'(MAX_ITER);
  localparam logic [1:0]       WAIT_LOAD = 2'(CMP_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       wait_cnt;
  logic [CNT_W-1:0] iter_cnt;
  logic             en_pipe;
  logic             wr_square_s;
  logic             wr_square;
  logic             out_valid;
  logic             busy;
  logic             err;
  logic             cmp_vld;
  logic             accept;
  logic             cmp_hit;
  logic             timeout;

  sqrt_lat_shift #(
    .LAT(CMP_LAT)
  ) u_lat_shift (
    .clk  (clk),
    .rst  (rst),
    .issue(en_pipe),
    .qual (cmp_vld)
  );

  assign accept  = (state == ST_IDLE) && bus.in_valid_i;
  assign cmp_hit = (state == ST_ITER) && cmp_vld && bus.cmp_gt_i;
  // A qualified compare in the last allowed iteration wins over the limit.
  assign timeout = (state == ST_ITER) && !cmp_hit && (iter_cnt == ITER_LIM);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_INIT;
      ST_INIT: state_nxt = ST_ITER;
      ST_ITER: if (cmp_hit || timeout) state_nxt = (CMP_LAT == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (wait_cnt == '0) state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      iter_cnt    <= '0;
      en_pipe     <= 1'b0;
      wr_square_s <= 1'b0;
      wr_square   <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      en_pipe     <= is_pipe_state(state_nxt);
      wr_square_s <= (state_nxt == ST_ITER);
      wr_square   <= (state_nxt == ST_ITER) && !((state == ST_ITER) && wr_square);
      out_valid   <= (state_nxt == ST_DONE);
      busy        <= (state_nxt != ST_IDLE);

      if (accept) begin
        iter_cnt <= '0;
      end else if (state_nxt == ST_ITER) begin
        iter_cnt <= iter_cnt + CNT_W'(1);
      end

      if (accept) begin
        err <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end

      if (state == ST_ITER) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
    end
  end

  assign bus.in_ready_o    = (state == ST_IDLE);
  assign bus.wr_input_o    = accept;
  assign bus.en_pipe_o     = en_pipe;
  assign bus.wr_square_s_o = wr_square_s;
  assign bus.wr_square_o   = wr_square;
  assign bus.out_valid_o   = out_valid;
  assign bus.busy_o        = busy;
  assign bus.err_o         = err;
  assign bus.iter_cnt_o    = iter_cnt;

  a_wr_input_idle: assert property (@(posedge clk) disable iff (rst)
    bus.wr_input_o |-> (state == ST_IDLE));

  a_no_pipe_settle: assert property (@(posedge clk) disable iff (rst)
    bus.en_pipe_o |-> ((state != ST_WAIT) && (state != ST_DONE)));

  a_init_square_sel: assert property (@(posedge clk) disable iff (rst)
    (bus.en_pipe_o && !bus.wr_square_s_o) |-> (state == ST_INIT));

endmodule
